shop_identify: RTL

Sequential identifier for the 3-input gate-function selector (XOR3 / NAND3 / NOR3 / XNOR3). It drives all 8 input patterns into the unit under identification, samples its 1-bit result, and decodes the observed truth table back into the 2-bit function code. It is the reverse of the selector: result in, code out. It sits on the selector's a/b/c/f pins in self-test and bring-up benches.

---
 rtl/shop_identify.sv | 97 +++++++++
 1 files changed

// File: rtl/shop_identify.sv
// rtl/shop_identify.sv - sequential truth-table identifier for the XOR3/NAND3/NOR3/XNOR3 selector
module shop_identify #(
    parameter int RESP_LAT = 1,
    parameter int TT_W     = 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic            i_f,
    output logic            o_a,
    output logic            o_b,
    output logic            o_c,
    output logic            o_busy,
    output logic            o_valid,
    output logic [1:0]      o_code,
    output logic            o_match,
    output logic [TT_W-1:0] o_table
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [3:0] LAT    = 4'(RESP_LAT);

    logic [1:0]      state;
    logic [2:0]      pat;
    logic [3:0]      wcnt;
    logic [TT_W-1:0] shadow;
    logic [1:0]      dec_code;
    logic            dec_match;

    // Pattern pins are only driven while probing; they idle at zero.
    assign {o_a, o_b, o_c} = (state == S_RUN) ? pat : 3'b000;
    assign o_busy          = (state != S_IDLE);

    always_comb begin
        dec_code  = 2'b00;
        dec_match = 1'b0;
        case (shadow)
            8'h96: begin dec_code = 2'b00; dec_match = 1'b1; end
            8'h7F: begin dec_code = 2'b01; dec_match = 1'b1; end
            8'h01: begin dec_code = 2'b10; dec_match = 1'b1; end
            8'h69: begin dec_code = 2'b11; dec_match = 1'b1; end
            default: begin dec_code = 2'b00; dec_match = 1'b0; end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state   <= S_IDLE;
            pat     <= 3'd0;
            wcnt    <= 4'd0;
            shadow  <= '0;
            o_valid <= 1'b0;
            o_code  <= 2'b00;
            o_match <= 1'b0;
            o_table <= '0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        state  <= S_RUN;
                        pat    <= 3'd0;
                        wcnt   <= 4'd0;
                        shadow <= '0;
                    end
                end
                S_RUN: begin
                    // Sample on the last hold cycle so the unit has had RESP_LAT cycles to respond.
                    if (wcnt == LAT) begin
                        shadow[pat] <= i_f;
                        wcnt        <= 4'd0;
                        if (pat == 3'd7) begin
                            state <= S_DONE;
                        end else begin
                            pat <= pat + 3'd1;
                        end
                    end else begin
                        wcnt <= wcnt + 4'd1;
                    end
                end
                S_DONE: begin
                    o_table <= shadow;
                    o_code  <= dec_code;
                    o_match <= dec_match;
                    o_valid <= 1'b1;
                    state   <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
